key_conditioner: RTL and testbench

- Front-end for the board's active-low push-buttons (KEY[3:1] and similar).
- Synchronises, debounces and edge-detects each key. Emits single-cycle press pulses with optional auto-repeat while held, plus release pulses.
- Sits directly upstream of the clock/alarm/stopwatch core, which consumes key_pulse instead of raw KEY levels to step hour/minute/second by one per press.

---
 rtl/key_conditioner.sv | 158 +++++++++++++++
 tb/tb_key_conditioner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects active-low push
// buttons. Emits a one-cycle press pulse (plus optional auto-repeat while
// held) and a one-cycle release pulse per key. All outputs are registered.
module key_conditioner #(
  parameter int               NKEYS           = 3,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               HOLD_CYCLES     = 25000000,
  parameter int               REPEAT_CYCLES   = 5000000,
  parameter logic [NKEYS-1:0] REPEAT_EN       = {NKEYS{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_n_i,
  output logic [NKEYS-1:0] key_pressed,
  output logic [NKEYS-1:0] key_pulse,
  output logic [NKEYS-1:0] key_release
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_TERM = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_TERM  = RP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } state_t;

  logic [NKEYS-1:0] sync1_reg;
  logic [NKEYS-1:0] sync2_reg;

  // Two-flop synchroniser; resets to the released (high) level so that
  // leaving reset with a key already held looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= key_n_i;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic [DB_W-1:0] db_cnt_reg;
      logic            pressed_reg;
      logic            differ;
      logic            accept;
      logic            press_acc;
      logic            rel_acc;

      state_t          state_reg;
      state_t          state_next;
      logic [RP_W-1:0] rp_cnt_reg;
      logic [RP_W-1:0] rp_cnt_next;
      logic            pulse_reg;
      logic            pulse_next;
      logic            release_reg;
      logic            release_next;

      // Synchronised level (converted to 1 = pressed) disagrees with the
      // accepted level; acceptance happens on the terminal count.
      assign differ    = (~sync2_reg[gi]) != pressed_reg;
      assign accept    = differ && (db_cnt_reg == DB_TERM);
      assign press_acc = accept && !pressed_reg;
      assign rel_acc   = accept && pressed_reg;

      // Debounce: count consecutive disagreeing cycles, any agreement restarts.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt_reg  <= '0;
          pressed_reg <= 1'b0;
        end else if (!differ) begin
          db_cnt_reg  <= '0;
        end else if (db_cnt_reg == DB_TERM) begin
          db_cnt_reg  <= '0;
          pressed_reg <= ~pressed_reg;
        end else begin
          db_cnt_reg  <= db_cnt_reg + DB_W'(1);
        end
      end

      // Press/hold/repeat FSM state, counter and registered pulse outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg   <= RELEASED;
          rp_cnt_reg  <= '0;
          pulse_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          rp_cnt_reg  <= rp_cnt_next;
          pulse_reg   <= pulse_next;
          release_reg <= release_next;
        end
      end

      // Next-state logic; a release accepted on a repeat edge takes priority.
      always_comb begin
        state_next   = state_reg;
        rp_cnt_next  = rp_cnt_reg;
        pulse_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
          RELEASED: begin
            rp_cnt_next = '0;
            if (press_acc) begin
              pulse_next = 1'b1;
              state_next = HELD;
            end
          end
          HELD: begin
            if (rel_acc) begin
              release_next = 1'b1;
              rp_cnt_next  = '0;
              state_next   = RELEASED;
            end else if (!REPEAT_EN[gi]) begin
              rp_cnt_next = '0;
            end else if (rp_cnt_reg == HOLD_TERM) begin
              pulse_next  = 1'b1;
              rp_cnt_next = '0;
              state_next  = REPEAT;
            end else begin
              rp_cnt_next = rp_cnt_reg + RP_W'(1);
            end
          end
          REPEAT: begin
            if (rel_acc) begin
              release_next = 1'b1;
              rp_cnt_next  = '0;
              state_next   = RELEASED;
            end else if (rp_cnt_reg == REP_TERM) begin
              pulse_next  = 1'b1;
              rp_cnt_next = '0;
            end else begin
              rp_cnt_next = rp_cnt_reg + RP_W'(1);
            end
          end
          default: begin
            state_next  = RELEASED;
            rp_cnt_next = '0;
          end
        endcase
      end

      assign key_pressed[gi] = pressed_reg;
      assign key_pulse[gi]   = pulse_reg;
      assign key_release[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed stimulus against two instances (auto-repeat on
// all keys, and auto-repeat disabled on key 2), checked every cycle against a
// window/age model plus hand-computed literal expectations.
module tb_key_conditioner;

  localparam int NK   = 3;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam logic [NK-1:0] EN0 = 3'b111;
  localparam logic [NK-1:0] EN1 = 3'b011;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n_i = '0;
  logic [NK-1:0] pr0, pu0, re0;
  logic [NK-1:0] pr1, pu1, re1;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(EN0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_n_i),
    .key_pressed(pr0), .key_pulse(pu0), .key_release(re0)
  );

  key_conditioner #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(EN1)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_n_i),
    .key_pressed(pr1), .key_pulse(pu1), .key_release(re1)
  );

  int total = 0;
  int bad   = 0;

  // Observed pulse/release counts per instance and key, plus pressed cycles of key 1.
  int pc [2][NK];
  int rc [2][NK];
  int pk1;

  // Model state: raw samples of previous edges, accepted level, age since press.
  logic [NK-1:0] hist [0:DB];
  logic [NK-1:0] m_pressed;
  logic [NK-1:0] m_pulse [2];
  logic [NK-1:0] m_rel;
  int            m_age [NK];
  bit            all_diff;
  bit            rep;

  task automatic chk(input string name, input logic [NK-1:0] got, input logic [NK-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    for (int a = 0; a < 2; a++)
      for (int k = 0; k < NK; k++) begin
        pc[a][k] = 0;
        rc[a][k] = 0;
      end
    pk1 = 0;
  endtask

  // Model: a level change is accepted when the last DB synchronised samples
  // (raw samples two edges old and older) all disagree with the accepted
  // level. While pressed, repeats fire at ages HOLD, HOLD+REP, HOLD+2*REP...
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j <= DB; j++) hist[j] = '1;
      m_pressed  = '0;
      m_pulse[0] = '0;
      m_pulse[1] = '0;
      m_rel      = '0;
      for (int k = 0; k < NK; k++) m_age[k] = 0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        m_pulse[0][k] = 1'b0;
        m_pulse[1][k] = 1'b0;
        m_rel[k]      = 1'b0;
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++)
          if (hist[j][k] != m_pressed[k]) all_diff = 1'b0;
        if (all_diff && m_pressed[k]) begin
          m_pressed[k] = 1'b0;
          m_rel[k]     = 1'b1;
        end else if (all_diff) begin
          m_pressed[k]  = 1'b1;
          m_age[k]      = 0;
          m_pulse[0][k] = 1'b1;
          m_pulse[1][k] = 1'b1;
        end else if (m_pressed[k]) begin
          m_age[k]++;
          rep = (m_age[k] == HOLD) || (m_age[k] > HOLD && ((m_age[k] - HOLD) % REP) == 0);
          m_pulse[0][k] = EN0[k] && rep;
          m_pulse[1][k] = EN1[k] && rep;
        end
      end
      for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = key_n_i;
    end
    #1;
    chk("pressed_rep", pr0, m_pressed);
    chk("pulse_rep",   pu0, m_pulse[0]);
    chk("release_rep", re0, m_rel);
    chk("pressed_nr",  pr1, m_pressed);
    chk("pulse_nr",    pu1, m_pulse[1]);
    chk("release_nr",  re1, m_rel);
    for (int k = 0; k < NK; k++) begin
      pc[0][k] += int'(pu0[k]);
      pc[1][k] += int'(pu1[k]);
      rc[0][k] += int'(re0[k]);
      rc[1][k] += int'(re1[k]);
    end
    pk1 += int'(pr0[1]);
  end

  initial begin
    clr();
    // 1. Reset with all keys held, then leave reset.
    rst_n   = 1'b0;
    key_n_i = 3'b000;
    step(3);
    chk("t1_rst_pressed", pr0, 3'b000);
    chk("t1_rst_pulse",   pu0, 3'b000);
    chk("t1_rst_release", re0, 3'b000);
    rst_n = 1'b1;
    step(5);
    chk("t1_pulse_early", pu0, 3'b000);
    step(1);
    chk("t1_pulse",       pu0, 3'b111);
    chk("t1_pulse_nr",    pu1, 3'b111);
    chk("t1_pressed",     pr0, 3'b111);
    step(1);
    chk("t1_pulse_once",  pu0, 3'b000);
    key_n_i = 3'b111;
    step(6);
    chk("t1_release",     re0, 3'b111);
    chk("t1_unpressed",   pr0, 3'b000);
    step(1);
    chk("t1_release_end", re0, 3'b000);
    step(4);

    // 2. Clean press of key 0 held six samples.
    key_n_i = 3'b110;
    step(5);
    chk("t2_pulse_early", pu0, 3'b000);
    step(1);
    chk("t2_pulse",       pu0, 3'b001);
    chk("t2_pressed",     pr0, 3'b001);
    key_n_i = 3'b111;
    step(1);
    chk("t2_pulse_once",  pu0, 3'b000);
    step(4);
    chk("t2_still_held",  pr0, 3'b001);
    chk("t2_rel_early",   re0, 3'b000);
    step(1);
    chk("t2_release",     re0, 3'b001);
    chk("t2_unpressed",   pr0, 3'b000);
    step(1);
    chk("t2_release_end", re0, 3'b000);
    step(4);

    // 3. Bounce on key 1: low runs of three never reach acceptance.
    clr();
    begin
      logic [7:0] seq;
      seq = 8'b1000_1000;  // applied LSB first: 0,0,0,1,0,0,0,1
      for (int s = 0; s < 8; s++) begin
        key_n_i = {1'b1, seq[s], 1'b1};
        step(1);
      end
    end
    key_n_i = 3'b111;
    step(8);
    chk_int("t3_bounce_pulses",  pc[0][1], 0);
    chk_int("t3_bounce_pressed", pk1, 0);
    key_n_i = 3'b101;
    step(10);
    key_n_i = 3'b111;
    step(8);
    chk_int("t3_hold_pulses",    pc[0][1], 1);
    chk_int("t3_hold_pulses_nr", pc[1][1], 1);
    chk_int("t3_hold_releases",  rc[0][1], 1);

    // 4/5a. Key 2 held 30 samples: pressed from age 0 to release at age 30,
    // pulses at ages 0,10,13,16,19,22,25,28 -> 8; repeat disabled -> 1.
    clr();
    key_n_i = 3'b011;
    step(30);
    key_n_i = 3'b111;
    step(8);
    chk_int("t4_repeat_pulses",  pc[0][2], 8);
    chk_int("t4_norepeat_pulse", pc[1][2], 1);
    chk_int("t4_release",        rc[0][2], 1);
    chk_int("t4_release_nr",     rc[1][2], 1);

    // 5b. Key 0 held 28 samples: release accepted at age 28 = 10+6*3,
    // the same edge a repeat would fire; release must win.
    clr();
    key_n_i = 3'b110;
    step(28);
    key_n_i = 3'b111;
    step(5);
    chk("t5_pre_release", re0, 3'b000);
    step(1);
    chk("t5_coll_release", re0, 3'b001);
    chk("t5_coll_pulse",   pu0, 3'b000);
    step(4);
    chk_int("t5_pulses",   pc[0][0], 7);
    chk_int("t5_releases", rc[0][0], 1);

    // 6. Asynchronous reset while key 0 is auto-repeating.
    key_n_i = 3'b110;
    step(20);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pressed", pr0, 3'b000);
    chk("t6_async_pulse",   pu0, 3'b000);
    chk("t6_async_release", re0, 3'b000);
    chk("t6_async_pressed_nr", pr1, 3'b000);
    step(2);
    rst_n = 1'b1;
    clr();
    step(5);
    chk("t6_pulse_early", pu0, 3'b000);
    chk("t6_not_pressed", pr0, 3'b000);
    step(1);
    chk("t6_fresh_pulse", pu0, 3'b001);
    chk("t6_pressed",     pr0, 3'b001);
    key_n_i = 3'b111;
    step(8);
    chk_int("t6_pulse_count", pc[0][0], 1);
    chk_int("t6_release_cnt", rc[0][0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
